// File: rtl/spi_temp_sensor.sv
// SPI temperature-sensor slave clocked from the system clock: serves one of
// NUM_CH live temperature words per frame and accepts a channel/shutdown write word.
module spi_temp_sensor #(
    parameter int          DATA_W = 16,
    parameter int          NUM_CH = 4,
    parameter int          CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter logic [15:0] DEV_ID = 16'h800F
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     sck_i,
    input  logic                     cs_i,
    input  logic                     si_i,
    output logic                     sio_o,
    output logic                     so_en_o,
    input  logic [NUM_CH*DATA_W-1:0] temp_in_i,
    output logic [CH_W-1:0]          ch_sel_o,
    output logic                     shutdown_o,
    output logic                     frame_done_o
);

    localparam int                CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [DATA_W-1:0] ID_WORD  = DATA_W'(DEV_ID);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    // [0] first sync stage, [1] synchronised value, [2] previous synchronised value
    logic [2:0] sck_pipe_q;
    logic [2:0] cs_pipe_q;
    logic [1:0] si_pipe_q;

    logic sck_rise, sck_fall, cs_fall, cs_rise, si_sync;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]   shift_out_q, shift_out_d;
    logic [DATA_W-2:0]   shift_in_q, shift_in_d;
    logic                sio_q, sio_d;
    logic                so_en_q, so_en_d;
    logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
    logic                shutdown_q, shutdown_d;
    logic                frame_done_q, frame_done_d;

    logic [DATA_W-1:0]   temp_ch [NUM_CH];
    logic [DATA_W-1:0]   load_word;
    logic [DATA_W-1:0]   word_in;
    logic [CH_W-1:0]     ch_req;
    logic [CNT_W-1:0]    cnt_inc;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_temp_ch
        assign temp_ch[k] = temp_in_i[k*DATA_W +: DATA_W];
    end

    // CS resets high so an idle bus never produces a spurious select edge
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sck_pipe_q <= 3'b000;
            cs_pipe_q  <= 3'b111;
            si_pipe_q  <= 2'b00;
        end else begin
            sck_pipe_q <= {sck_pipe_q[1:0], sck_i};
            cs_pipe_q  <= {cs_pipe_q[1:0], cs_i};
            si_pipe_q  <= {si_pipe_q[0], si_i};
        end
    end

    assign sck_rise = sck_pipe_q[1] & ~sck_pipe_q[2];
    assign sck_fall = ~sck_pipe_q[1] & sck_pipe_q[2];
    assign cs_fall  = ~cs_pipe_q[1] & cs_pipe_q[2];
    assign cs_rise  = cs_pipe_q[1] & ~cs_pipe_q[2];
    assign si_sync  = si_pipe_q[1];

    assign load_word = shutdown_q ? ID_WORD : temp_ch[ch_sel_q];
    assign word_in   = {shift_in_q, si_sync};
    assign ch_req    = word_in[CH_W-1:0];
    assign cnt_inc   = bit_cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_out_q  <= '0;
            shift_in_q   <= '0;
            sio_q        <= 1'b0;
            so_en_q      <= 1'b0;
            ch_sel_q     <= '0;
            shutdown_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_out_q  <= shift_out_d;
            shift_in_q   <= shift_in_d;
            sio_q        <= sio_d;
            so_en_q      <= so_en_d;
            ch_sel_q     <= ch_sel_d;
            shutdown_q   <= shutdown_d;
            frame_done_q <= frame_done_d;
        end
    end

    // shift_out holds only the bits still to be sent; the bit on the pin lives in sio
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_out_d  = shift_out_q;
        shift_in_d   = shift_in_q;
        sio_d        = sio_q;
        so_en_d      = so_en_q;
        ch_sel_d     = ch_sel_q;
        shutdown_d   = shutdown_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    shift_out_d = load_word[DATA_W-2:0];
                    sio_d       = load_word[DATA_W-1];
                    so_en_d     = 1'b1;
                    bit_cnt_d   = '0;
                    state_d     = READ;
                end
            end

            READ: begin
                if (cs_rise) begin
                    sio_d   = 1'b0;
                    so_en_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (sck_fall) begin
                        sio_d       = shift_out_q[DATA_W-2];
                        shift_out_d = {shift_out_q[DATA_W-3:0], 1'b0};
                    end
                    if (sck_rise) begin
                        bit_cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            bit_cnt_d = '0;
                            sio_d     = 1'b0;
                            state_d   = WRITE;
                        end
                    end
                end
            end

            WRITE: begin
                if (cs_rise) begin
                    sio_d   = 1'b0;
                    so_en_d = 1'b0;
                    state_d = IDLE;
                end else if (sck_rise) begin
                    shift_in_d = word_in[DATA_W-2:0];
                    bit_cnt_d  = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        if (&word_in) begin
                            shutdown_d = 1'b1;
                        end else begin
                            shutdown_d = 1'b0;
                            ch_sel_d   = (ch_req > LAST_CH) ? LAST_CH : ch_req;
                        end
                        frame_done_d = 1'b1;
                        sio_d        = 1'b0;
                        so_en_d      = 1'b0;
                        state_d      = DONE;
                    end
                end
            end

            DONE: begin
                sio_d   = 1'b0;
                so_en_d = 1'b0;
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sio_o        = sio_q;
    assign so_en_o      = so_en_q;
    assign ch_sel_o     = ch_sel_q;
    assign shutdown_o   = shutdown_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_spi_temp_sensor.sv
// Randomised bench for spi_temp_sensor: an SPI master drives frames while a
// device-level model predicts read words, channel selection and shutdown.
module tb_spi_temp_sensor;

    localparam int          DW     = 16;
    localparam int          NCH    = 3;
    localparam int          CHW    = 2;
    localparam logic [15:0] DEVID  = 16'h800F;

    logic                clk;
    logic                reset;
    logic                sck;
    logic                cs;
    logic                si;
    logic                sio;
    logic                soEn;
    logic [NCH*DW-1:0]   tempIn;
    logic [CHW-1:0]      chSel;
    logic                shutdown;
    logic                frameDone;

    int totalChecks = 0;
    int badChecks   = 0;
    int fdCycles    = 0;

    // device-level model: what the sensor should hold between frames
    logic [15:0] tempM [NCH];
    int          chM = 0;
    bit          shM = 0;

    spi_temp_sensor #(
        .DATA_W (DW),
        .NUM_CH (NCH),
        .CH_W   (CHW),
        .DEV_ID (DEVID)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .sck_i        (sck),
        .cs_i         (cs),
        .si_i         (si),
        .sio_o        (sio),
        .so_en_o      (soEn),
        .temp_in_i    (tempIn),
        .ch_sel_o     (chSel),
        .shutdown_o   (shutdown),
        .frame_done_o (frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // counts clocks with frame_done high, so a stretched pulse shows up as extra counts
    always @(negedge clk) begin
        if (frameDone === 1'b1) fdCycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic packTemps();
        for (int k = 0; k < NCH; k++) tempIn[k*DW +: DW] = tempM[k];
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Sio"}, sio, 0);
        checkOutput({tag, "SoEn"}, soEn, 0);
        checkOutput({tag, "ChSel"}, chSel, 0);
        checkOutput({tag, "Shutdown"}, shutdown, 0);
        checkOutput({tag, "FrameDone"}, frameDone, 0);
    endtask

    // one CS-low frame of nCycles SCK cycles; fewer than 32 cycles is an abort
    task automatic applyStimulus(input int nCycles, input logic [15:0] wWord);
        logic [15:0] expRead;
        logic [15:0] got;
        int          fd0;
        int          idx;
        got     = '0;
        expRead = shM ? DEVID : tempM[chM];
        fd0     = fdCycles;
        packTemps();
        cs = 1'b0;
        waitClk(6);
        for (int i = 0; i < nCycles; i++) begin
            si = (i >= 16 && i < 32) ? wWord[31-i] : 1'b0;
            if (i == 5) begin
                for (int k = 0; k < NCH; k++) tempM[k] = 16'($urandom);
                packTemps();
            end
            waitClk($urandom_range(4, 6));
            sck = 1'b1;
            if (i < 16) got[15-i] = sio;
            if (i >= 32) begin
                checkOutput("overrunSio", sio, 0);
                checkOutput("overrunSoEn", soEn, 0);
            end
            waitClk($urandom_range(4, 6));
            sck = 1'b0;
        end
        si = 1'b0;
        waitClk(4);
        checkOutput("soEnBeforeCsRise", soEn, (nCycles < 32) ? 1 : 0);
        cs = 1'b1;
        waitClk(2);
        if (nCycles < 32) checkOutput("soEnHeld", soEn, 1);
        waitClk(1);
        checkOutput("soEnOff", soEn, 0);
        waitClk(4);
        if (nCycles >= 16) checkOutput("readWord", got, expRead);
        if (nCycles >= 32) begin
            if (wWord == 16'hFFFF) begin
                shM = 1;
            end else begin
                shM = 0;
                idx = int'(wWord) % (1 << CHW);
                chM = (idx >= NCH) ? NCH - 1 : idx;
            end
        end
        checkOutput("frameDoneCount", fdCycles - fd0, (nCycles >= 32) ? 1 : 0);
        checkOutput("chSel", chSel, chM);
        checkOutput("shutdown", shutdown, shM);
    endtask

    initial begin
        int r;
        int nCyc;
        logic [15:0] w;
        reset = 1'b1;
        cs    = 1'b1;
        sck   = 1'b0;
        si    = 1'b0;
        for (int k = 0; k < NCH; k++) tempM[k] = '0;
        packTemps();
        waitClk(3);
        checkResetOutputs("reset");
        reset = 1'b0;
        waitClk(5);

        $display("[TB] normal read");
        tempM[0] = 16'h4400;
        applyStimulus(32, 16'h0000);

        $display("[TB] channel select");
        applyStimulus(32, 16'h0002);
        tempM[2] = 16'h1A50;
        applyStimulus(32, 16'h0000);

        $display("[TB] shutdown and ID");
        applyStimulus(32, 16'hFFFF);
        applyStimulus(32, 16'h0001);

        $display("[TB] abort during write");
        applyStimulus(20, 16'hFFFF);
        applyStimulus(32, 16'h0001);

        $display("[TB] clamp with overrun clocks");
        applyStimulus(40, 16'h0003);

        $display("[TB] random frames");
        for (int n = 0; n < 20; n++) begin
            r = $urandom_range(0, 9);
            w = (r == 0) ? 16'hFFFF : 16'($urandom);
            r = $urandom_range(0, 5);
            nCyc = (r == 0) ? $urandom_range(1, 31) : (r == 1) ? 32 + $urandom_range(1, 8) : 32;
            applyStimulus(nCyc, w);
        end

        $display("[TB] async reset mid-read");
        applyStimulus(32, 16'h0002);
        cs = 1'b0;
        waitClk(6);
        for (int i = 0; i < 5; i++) begin
            waitClk(4);
            sck = 1'b1;
            waitClk(4);
            sck = 1'b0;
        end
        waitClk(4);
        sck = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs("asyncReset");
        sck = 1'b0;
        cs  = 1'b1;
        waitClk(3);
        reset = 1'b0;
        chM = 0;
        shM = 0;
        waitClk(6);
        applyStimulus(32, 16'h0001);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/spi_temp_sensor.md
# spi_temp_sensor

Parametrised, synthesisable SPI temperature-sensor slave. It is the next generation of the LM70-style sensor model and serves as a drop-in target for the SPI master under test. Unlike the single-channel fixed-value model, it runs on a system clock, samples SCK/CS through synchronisers, and serves any of NUM_CH live temperature inputs. It also accepts a host write word after the read phase, which either selects the channel or enters/leaves shutdown (ID readback).

## Interface
- DATA_W, 16, bits per read phase and per write phase; ≥ 8
- NUM_CH, 4, number of temperature channels; ≥ 1
- CH_W, $clog2(NUM_CH) (min 1), channel-select width
- DEV_ID, 16'h800F, word returned while in shutdown (lower DATA_W bits)
- clk  input  1  system clock; ≥ 4× SCK frequency
- reset  input  1  asynchronous, active-high; clears all state
- SCK  input  1  SPI clock from master, asynchronous to clk, idles low
- CS  input  1  SPI chip select, active-low, asynchronous to clk
- SI  input  1  serial data from master, sampled on SCK rising edges
- SIO  output  1  serial data to master, MSB first
- so_en  output  1  high while SIO is driven (CS low and frame not done)
- temp_in  input  NUM_CH*DATA_W  channel temperatures, channel k at [k*DATA_W +: DATA_W]
- ch_sel  output  CH_W  currently selected channel
- shutdown  output  1  shutdown mode flag
- frame_done  output  1  one-clk pulse on a completed 2*DATA_W-bit frame

## Operation
- Input conditioning: SCK, CS, and SI each go through a 2-FF synchroniser. A registered previous-value stage gives sck_rise, sck_fall, cs_fall, and cs_rise as single-clk strobes.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On cs_fall, load shift_out with DEV_ID[DATA_W-1:0] if shutdown, else the temp_in slice for ch_sel.
  - Drive SIO = shift_out MSB, clear bit_cnt, go to READ.
  - SCK edges in the same clk as cs_fall are ignored.
- READ:
  - On each sck_fall, shift shift_out left, fill with 0, and set SIO to the new MSB.
  - On each sck_rise, increment bit_cnt.
  - When bit_cnt reaches DATA_W on a rise, go to WRITE with bit_cnt = 0.
- WRITE:
  - On each sck_rise, shift sync'd SI into shift_in LSB-first-in (the MSB arrives first) and increment bit_cnt.
  - SIO = 0 throughout.
  - On the rise that makes bit_cnt = DATA_W, commit the word:
    - All ones: shutdown ← 1.
    - Else: shutdown ← 0 and ch_sel ← shift_in[CH_W-1:0]; indices ≥ NUM_CH clamp to NUM_CH-1.
  - Then pulse frame_done and go to DONE.
- DONE: SCK edges are ignored, SIO = 0, so_en = 0. On cs_rise, go to IDLE.
- cs_rise in READ or WRITE aborts the frame: go to IDLE with no commit, no frame_done, and ch_sel/shutdown unchanged.
- reset mid-frame: immediate return to IDLE with all outputs at reset values.
- Temperature is captured once per frame at cs_fall. Later changes to temp_in do not affect the frame in progress.

## Timing
- Reset values: SIO=0, so_en=0, ch_sel=0, shutdown=0, frame_done=0, state IDLE, bit_cnt=0.
- Pin-to-strobe latency is 3 clk: 2 synchroniser clks plus 1 edge-detect clk.
- SIO/so_en update on the clk edge where the strobe is high, so the pin-to-SIO delay is 3 clk after a CS falling or SCK falling pin edge.
- Master must keep SCK high and low phases each ≥ 2 clk periods. CS-fall to first SCK rise must be ≥ 4 clk.
- Commit: ch_sel/shutdown/frame_done change in the clk of the last sck_rise strobe. frame_done is high for exactly 1 clk.
- so_en = 1 from the cs_fall strobe until the commit clk or cs_rise strobe, whichever comes first.
- bit_cnt is $clog2(DATA_W)+1 bits wide and never wraps within a frame.

## Test plan
- Normal read:
  - Stimulus: temp_in ch0 = 16'h4400, ch_sel=0, 16 SCK cycles with SI=0, then 16 SCK cycles with SI=0.
  - Required: SIO shifts out 0100_0100_0000_0000; ch_sel stays 0; one frame_done pulse.
- Channel select:
  - Stimulus: write word 16'h0002, then a second frame with ch2 = 16'h1A50.
  - Required: ch_sel=2 after frame 1; frame 2 reads 16'h1A50.
- Shutdown/ID:
  - Stimulus: write 16'hFFFF; next frame, then write 16'h0001.
  - Required: shutdown=1 and next frame reads 16'h800F; after the 16'h0001 write, shutdown=0 and ch_sel=1.
- Abort:
  - Stimulus: raise CS after 20 SCK cycles while writing 16'hFFFF.
  - Required: no frame_done, shutdown stays 0, so_en drops 3 clk after CS rises; the next full frame works normally.
- Clamp/overrun:
  - Stimulus: NUM_CH=3, write 16'h0003, then 8 extra SCK cycles before CS rise.
  - Required: ch_sel=2; SIO=0 and so_en=0 during the extra clocks; a single frame_done.
- Async reset mid-READ:
  - Stimulus: assert reset at bit 5 of a read.
  - Required: all outputs at reset values immediately, independent of clk; after release, the next CS fall starts a clean frame.
